// File: rtl/pe_array_feeder_pkg.sv
// rtl/pe_array_feeder_pkg.sv - shared sizes and FSM encodings for the PE array feeder
package pe_array_feeder_pkg;

  localparam int FEEDER_N  = 8;
  localparam int FEEDER_DW = 16;
  localparam int FEEDER_KW = 7;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CLEAR  = 3'd1;
  localparam state_t ST_STREAM = 3'd2;
  localparam state_t ST_FLUSH  = 3'd3;
  localparam state_t ST_WAIT   = 3'd4;

endpackage

// File: rtl/pe_array_feeder_if.sv
// rtl/pe_array_feeder_if.sv - job, beat and cluster-side signals of the PE array feeder
interface pe_array_feeder_if #(
  parameter int N  = pe_array_feeder_pkg::FEEDER_N,
  parameter int DW = pe_array_feeder_pkg::FEEDER_DW,
  parameter int KW = pe_array_feeder_pkg::FEEDER_KW
);

  logic            start;
  logic [KW-1:0]   k_len;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] a_vec;
  logic [N*DW-1:0] w_vec;
  logic [N*DW-1:0] activations;
  logic [N*DW-1:0] weights;
  logic [N-1:0]    done;
  logic            array_en;
  logic [N*N-1:0]  array_dones;
  logic            busy;
  logic            job_done;

  modport master (
    output start, k_len, in_valid, a_vec, w_vec, array_dones,
    input  in_ready, activations, weights, done, array_en, busy, job_done
  );

  modport slave (
    input  start, k_len, in_valid, a_vec, w_vec, array_dones,
    output in_ready, activations, weights, done, array_en, busy, job_done
  );

endinterface

// File: rtl/pe_array_feeder_skew_delay_line.sv
// rtl/pe_array_feeder_skew_delay_line.sv - DEPTH-stage register chain carrying {last_tag, data}
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] i_data,
  input  logic          i_tag,
  output logic [DW-1:0] o_data,
  output logic          o_tag
);

  logic [DW:0] r_stage [DEPTH];

  // shift tag and data one stage per cycle; reset empties the whole chain
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) r_stage[s] <= '0;
    end else begin
      r_stage[0] <= {i_tag, i_data};
      for (int s = 1; s < DEPTH; s++) r_stage[s] <= r_stage[s-1];
    end
  end

  assign {o_tag, o_data} = r_stage[DEPTH-1];

endmodule

// File: rtl/pe_array_feeder.sv
// rtl/pe_array_feeder.sv - skewing feeder and job sequencer for the 8x8 PE cluster; FEEDER_PERF_EN adds perf counters
module pe_array_feeder #(
  parameter int N  = pe_array_feeder_pkg::FEEDER_N,
  parameter int DW = pe_array_feeder_pkg::FEEDER_DW,
  parameter int KW = pe_array_feeder_pkg::FEEDER_KW
) (
  input  logic                clk,
  input  logic                rst,
  pe_array_feeder_if.slave    bus
`ifdef FEEDER_PERF_EN
  ,
  output logic [31:0]         perf_cycles,
  output logic [31:0]         perf_bubbles
`endif
);

  import pe_array_feeder_pkg::*;

  localparam int              FW         = $clog2(N + 1);
  localparam logic [FW-1:0]   FLUSH_LAST = FW'(N - 1);
  localparam logic [KW-1:0]   K_ONE      = KW'(1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [KW-1:0]   r_k_len;
  logic [KW-1:0]   r_k_cnt;
  logic [FW-1:0]   r_flush_cnt;
  logic            r_busy;
  logic            r_en;
  logic [N-1:0]    r_done_hold;

  logic            w_start_ok;
  logic            w_accept;
  logic            w_last;
  logic            w_all_done;
  logic            w_job_done;
  logic [N-1:0]    w_tag_out;
  logic [N*DW-1:0] w_act;
  logic [N*DW-1:0] w_wgt;

  assign w_start_ok = (r_state == ST_IDLE) && bus.start && (bus.k_len != '0);
  assign w_accept   = (r_state == ST_STREAM) && bus.in_valid;
  assign w_last     = w_accept && ((r_k_cnt + K_ONE) == r_k_len);
  assign w_all_done = &bus.array_dones;
  assign w_job_done = (r_state == ST_WAIT) && w_all_done;

  // next-state selection for the job sequencer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_start_ok) w_state_nxt = ST_CLEAR;
      ST_CLEAR:  w_state_nxt = ST_STREAM;
      ST_STREAM: if (w_last) w_state_nxt = ST_FLUSH;
      ST_FLUSH:  if (r_flush_cnt == FLUSH_LAST) w_state_nxt = ST_WAIT;
      ST_WAIT:   if (w_all_done) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state, beat/flush counters, busy and the cluster enable (low only while clearing)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_k_len     <= '0;
      r_k_cnt     <= '0;
      r_flush_cnt <= '0;
      r_busy      <= 1'b0;
      r_en        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_en    <= (w_state_nxt != ST_CLEAR);
      if (w_start_ok) begin
        r_k_len <= bus.k_len;
        r_busy  <= 1'b1;
      end else if (w_job_done) begin
        r_busy  <= 1'b0;
      end
      if (r_state == ST_CLEAR) r_k_cnt <= '0;
      else if (w_accept)       r_k_cnt <= r_k_cnt + K_ONE;
      if (r_state == ST_FLUSH) r_flush_cnt <= r_flush_cnt + 1'b1;
      else                     r_flush_cnt <= '0;
    end
  end

  // per-row done flags latch when the tagged element leaves a lane, cleared by the next job
  always_ff @(posedge clk) begin
    if (rst)                       r_done_hold <= '0;
    else if (r_state == ST_CLEAR)  r_done_hold <= '0;
    else                           r_done_hold <= r_done_hold | w_tag_out;
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] w_a_in;
    logic [DW-1:0] w_w_in;
    logic          w_a_tag;
    logic          w_w_tag;

    // bubbles and idle cycles push zeros so a/w stay paired
    assign w_a_in = w_accept ? bus.a_vec[i*DW +: DW] : '0;
    assign w_w_in = w_accept ? bus.w_vec[i*DW +: DW] : '0;

    skew_delay_line #(.DEPTH(i + 1), .DW(DW)) u_a_line (
      .clk    (clk),
      .rst    (rst),
      .i_data (w_a_in),
      .i_tag  (w_last),
      .o_data (w_act[i*DW +: DW]),
      .o_tag  (w_a_tag)
    );

    skew_delay_line #(.DEPTH(i + 1), .DW(DW)) u_w_line (
      .clk    (clk),
      .rst    (rst),
      .i_data (w_w_in),
      .i_tag  (w_last),
      .o_data (w_wgt[i*DW +: DW]),
      .o_tag  (w_w_tag)
    );

    // both halves of a lane carry the same tag
    assign w_tag_out[i] = w_a_tag & w_w_tag;
  end

  assign bus.in_ready    = (r_state == ST_STREAM);
  assign bus.array_en    = r_en;
  assign bus.busy        = r_busy;
  assign bus.job_done    = w_job_done;
  assign bus.done        = r_done_hold | w_tag_out;
  assign bus.activations = w_act;
  assign bus.weights     = w_wgt;

`ifdef FEEDER_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_bubbles;

  // job length and stream bubble counters: clear on start, saturate, hold once idle
  always_ff @(posedge clk) begin
    if (rst || w_start_ok) begin
      r_perf_cycles  <= '0;
      r_perf_bubbles <= '0;
    end else begin
      if (r_busy && (r_perf_cycles != '1))
        r_perf_cycles <= r_perf_cycles + 32'd1;
      if ((r_state == ST_STREAM) && !bus.in_valid && (r_perf_bubbles != '1))
        r_perf_bubbles <= r_perf_bubbles + 32'd1;
    end
  end

  assign perf_cycles  = r_perf_cycles;
  assign perf_bubbles = r_perf_bubbles;
`endif

endmodule
